// File: rtl/rx_decode_sequencer_pkg.sv
// Shared types and widths for the RX decode sequencer and its codeword FIFO.
package rx_decode_sequencer_pkg;

  localparam int unsigned CwWidth   = 7;  // Hamming(7,4) codeword
  localparam int unsigned DataWidth = 4;  // decoded nibble
  localparam int unsigned ErrWidth  = 8;  // saturating error counter

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StHold  = 2'd3
  } state_e;

endpackage

// File: rtl/rx_codeword_fifo.sv
// Small circular buffer of received codewords; head is the oldest entry.
module rx_codeword_fifo
  import rx_decode_sequencer_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [CwWidth-1:0] wdata,
  output logic               full,
  output logic               empty,
  output logic [CwWidth-1:0] head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [CwWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A push into a full buffer still lands if the same cycle frees a slot.
  assign do_push = push & (~full | do_pop);

  // Occupancy bookkeeping for simultaneous push/pop.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only entries behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rx_decode_sequencer.sv
// Buffers UART codewords, feeds them one at a time to a Hamming decoder and
// holds each decoded nibble until the consumer takes it.
module rx_decode_sequencer
  import rx_decode_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DEC_TIMEOUT = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 uart_valid,
  input  logic [CwWidth-1:0]   uart_data,
  output logic                 dec_ena,
  output logic [CwWidth-1:0]   dec_in,
  input  logic                 dec_valid,
  input  logic [DataWidth-1:0] dec_data,
  input  logic [2:0]           dec_syndrome,
  output logic                 out_valid,
  output logic [DataWidth-1:0] out_data,
  input  logic                 out_ready,
  output logic [ErrWidth-1:0]  err_count,
  output logic [3:0]           status
);

  localparam int unsigned TimerW = $clog2(DEC_TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimeoutVal = TimerW'(DEC_TIMEOUT);

  state_e               state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d, timer_inc;
  logic                 dec_ena_q, dec_ena_d;
  logic [CwWidth-1:0]   dec_in_q, dec_in_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic [ErrWidth-1:0]  err_q, err_d;
  logic                 overflow_q, overflow_d;
  logic                 timeout_q, timeout_d;
  logic                 pop_req;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CwWidth-1:0]   fifo_head;

  assign fifo_push = ena & uart_valid;
  assign fifo_pop  = ena & pop_req;

  rx_codeword_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (uart_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign timer_inc = timer_q + TimerW'(1);

  // Next-state logic for the issue/wait/hold sequence.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    dec_ena_d  = 1'b0;
    dec_in_d   = dec_in_q;
    out_data_d = out_data_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    pop_req    = 1'b0;
    // A drop only happens when the buffer is full and no slot frees this cycle.
    overflow_d = overflow_q | (fifo_push & fifo_full & ~fifo_pop);
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StIssue;
      end
      StIssue: begin
        dec_ena_d = 1'b1;
        dec_in_d  = fifo_head;
        pop_req   = 1'b1;
        timer_d   = '0;
        state_d   = StWait;
      end
      StWait: begin
        // A result in the final cycle beats the timeout.
        if (dec_valid) begin
          out_data_d = dec_data;
          if ((dec_syndrome != 3'b000) && (err_q != '1)) err_d = err_q + ErrWidth'(1);
          state_d = StHold;
        end else if (timer_inc == TimeoutVal) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          timer_d = timer_inc;
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; ena low freezes everything and suppresses the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      dec_ena_q  <= 1'b0;
      dec_in_q   <= '0;
      out_data_q <= '0;
      err_q      <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      dec_ena_q  <= dec_ena_d;
      dec_in_q   <= dec_in_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end else begin
      dec_ena_q  <= 1'b0;
    end
  end

  assign dec_ena   = dec_ena_q;
  assign dec_in    = dec_in_q;
  assign out_valid = (state_q == StHold);
  assign out_data  = out_data_q;
  assign err_count = err_q;
  assign status    = {overflow_q, timeout_q, state_q};

endmodule
